vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Upstream stage of the VGA top level. Runs entirely on the 50 MHz board clock and produces the pixel-rate strobe, the vgaclk output for the DAC, sync/blank signals and pixel coordinates.
- The downstream pixel/colour generator consumes x, y, active and pix_en and drives r/g/b. vgaclk, horiz_sync, vert_sync, vga_sync and vga_blank go straight to the board pins.
- Defaults give 640x480@60 Hz at a 25 MHz pixel rate.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, asserted level of horiz_sync
- VS_POL, 0, asserted level of vert_sync
- CLK_DIV, 2, clk_fpga cycles per pixel; must be even and >=2

Ports:
- clk_fpga  in  1  board clock; the only clock
- reset  in  1  synchronous, active-high
- vgaclk  out  1  pixel clock to DAC, registered, 50% duty
- pix_en  out  1  one-cycle strobe in the last clk_fpga cycle of each pixel period
- horiz_sync  out  1  horizontal sync
- vert_sync  out  1  vertical sync
- vga_sync  out  1  DAC sync-on-green; tied 0
- vga_blank  out  1  DAC blank_n: 1 in visible area, 0 in blanking
- active  out  1  same as vga_blank, for internal consumers
- x  out  10  horizontal count hcnt, 0..H_TOTAL-1
- y  out  10  vertical count vcnt, 0..V_TOTAL-1
- line_end  out  1  pix_en AND hcnt==H_TOTAL-1
- frame_end  out  1  line_end AND vcnt==V_TOTAL-1

Behaviour:
- Totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 by default).
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525 by default).
  - Both must be <=1024.
- Divider:
  - div_cnt runs 0..CLK_DIV-1 and wraps.
  - vgaclk register = 1 when the next value of div_cnt >= CLK_DIV/2, else 0.
  - pix_en = (div_cnt==CLK_DIV-1), decoded from registered state.
- Counters:
  - Advance only on the clk_fpga edge where pix_en=1, which coincides with the vgaclk falling edge, so outputs are stable at the vgaclk rising edge.
  - hcnt wraps H_TOTAL-1 -> 0. vcnt increments when hcnt wraps. vcnt wraps V_TOTAL-1 -> 0.
- Decode (registered, updated on the same edge as the counters, so outputs always match the current x/y with zero skew):
  - active = (hcnt < H_ACTIVE) AND (vcnt < V_ACTIVE).
  - horiz_sync = HS_POL when hcnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), else ~HS_POL.
  - vert_sync = VS_POL when vcnt is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), else ~VS_POL. It changes only at line boundaries (hcnt -> 0).
  - line_end and frame_end are combinational from registered state, with no added latency.
- Reset values (next edge with reset=1):
  - div_cnt=0, hcnt=0, vcnt=0, vgaclk=0, pix_en=0.
  - horiz_sync=~HS_POL, vert_sync=~VS_POL.
  - vga_blank=1, active=1, vga_sync=0, line_end=0, frame_end=0.
- Reset mid-frame: all state returns to the reset values on the next edge. No partial sync pulse is extended. The first pixel after reset release is (0,0), lasting CLK_DIV cycles.
- Reset dominates pix_en on the same edge.
- Simultaneous wraps:
  - On the frame_end edge, hcnt->0 and vcnt->0 in the same cycle.
  - vert_sync deasserts/asserts on the same edge hcnt hits 0.

Test Plan:
- Reset (defaults):
  - Hold reset 3 cycles, release -> x=0, y=0, vga_blank=1, horiz_sync=1, vert_sync=1, vgaclk=0.
  - pix_en first high at the 2nd clk_fpga cycle after release, then every 2 cycles.
- Line timing:
  - Measure across one line -> line period 1600 clk_fpga cycles.
  - horiz_sync low for exactly 192 cycles, starting 1312 cycles after x=0.
  - vga_blank low for 320 cycles per line.
- Frame timing:
  - Run 2 frames -> frame_end pulses exactly 840000 cycles apart, each 1 cycle wide.
  - vert_sync low for 3200 cycles beginning when y becomes 490.
  - vga_blank=0 throughout y=480..524.
- Small override (H 8/2/2/2, V 4/1/1/1, CLK_DIV=4, HS_POL=VS_POL=1):
  - Line is 56 cycles and frame is 392 cycles.
  - horiz_sync high for x=10..11; vert_sync high for y=5.
  - vgaclk is 2 low / 2 high.
- Mid-frame reset:
  - Assert reset at x=700, y=491 (vert_sync asserted) for 1 cycle -> next cycle x=0, y=0, vert_sync=1, horiz_sync=1, div_cnt restarts.
  - The following frame_end is exactly 840000 cycles after release.
- Alignment check on every pix_en edge:
  - active == (x<640 && y<480) and vga_sync==0.
  - x/y change only on edges where pix_en=1.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA timing front end: pixel-rate divider, vgaclk, h/v counters and registered
// sync/blank decode, all on the single board clock.
module vga_timing_gen #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter bit          HS_POL   = 1'b0,
   parameter bit          VS_POL   = 1'b0,
   parameter int unsigned CLK_DIV  = 2
) (
   input  logic       clk_fpga,
   input  logic       reset,
   output logic       vgaclk,
   output logic       pix_en,
   output logic       horiz_sync,
   output logic       vert_sync,
   output logic       vga_sync,
   output logic       vga_blank,
   output logic       active,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       line_end,
   output logic       frame_end
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned DW      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
   localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);

   // 11-bit bounds so a sync window ending exactly at 1024 still compares correctly
   localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
   localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
   localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

   logic [DW-1:0] div_q, div_d;
   logic [9:0]    hcnt_q, hcnt_d;
   logic [9:0]    vcnt_q, vcnt_d;
   logic          vgaclk_q, vgaclk_d;
   logic          active_q, active_d;
   logic          hs_q, hs_d;
   logic          vs_q, vs_d;
   logic [10:0]   hx, vx;

   always_comb begin
      pix_en    = (div_q == DIV_LAST);
      line_end  = pix_en && (hcnt_q == H_LAST);
      frame_end = line_end && (vcnt_q == V_LAST);

      div_d  = pix_en ? '0 : div_q + 1'b1;
      hcnt_d = hcnt_q;
      vcnt_d = vcnt_q;
      if (pix_en) begin
         if (hcnt_q == H_LAST) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
         end else begin
            hcnt_d = hcnt_q + 1'b1;
         end
      end

      // Decode from next-state counts so the registered flags line up with x/y
      vgaclk_d = (div_d >= DIV_HALF);
      hx       = {1'b0, hcnt_d};
      vx       = {1'b0, vcnt_d};
      active_d = (hx < H_ACT) && (vx < V_ACT);
      hs_d     = ((hx >= HS_BEG) && (hx < HS_END)) ? HS_POL : ~HS_POL;
      vs_d     = ((vx >= VS_BEG) && (vx < VS_END)) ? VS_POL : ~VS_POL;
   end

   always_ff @(posedge clk_fpga) begin
      if (reset) begin
         div_q    <= '0;
         hcnt_q   <= '0;
         vcnt_q   <= '0;
         vgaclk_q <= 1'b0;
         active_q <= 1'b1;
         hs_q     <= ~HS_POL;
         vs_q     <= ~VS_POL;
      end else begin
         div_q    <= div_d;
         hcnt_q   <= hcnt_d;
         vcnt_q   <= vcnt_d;
         vgaclk_q <= vgaclk_d;
         active_q <= active_d;
         hs_q     <= hs_d;
         vs_q     <= vs_d;
      end
   end

   assign vgaclk     = vgaclk_q;
   assign horiz_sync = hs_q;
   assign vert_sync  = vs_q;
   assign vga_sync   = 1'b0;
   assign vga_blank  = active_q;
   assign active     = active_q;
   assign x          = hcnt_q;
   assign y          = vcnt_q;

endmodule
